// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the hazard / stall logic and
//                the forwarding unit that sits next to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Register index width used by the pipeline (8 GPRs, no hardwired zero).
    localparam int REG_ADDR_W_DEFAULT = 3;

    // Forwarding mux selects, shared with the forwarding unit.
    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // Stall controller states, explicitly encoded.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Pipeline-register control bundle driven by the stall controller.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } hz_ctrl_t;

    // Field order: pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold
    localparam hz_ctrl_t CTRL_RUN    = 5'b11000;
    localparam hz_ctrl_t CTRL_RESET  = 5'b00110;
    localparam hz_ctrl_t CTRL_FREEZE = 5'b00001;
    localparam hz_ctrl_t CTRL_FLUSH  = 5'b11110;
    localparam hz_ctrl_t CTRL_BUBBLE = 5'b00010;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_counter
//  Description : Saturating up-counter with synchronous reset and an
//                increment enable; sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;

    // Next count: step only when enabled and not already saturated.
    always_comb begin
        w_count_d = r_count;
        if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            w_count_d = r_count + CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Hazard detection and stall controller. Handles load-use
//                bubbles, data-memory busy freezes and taken-branch flushes,
//                drives the pipeline-register enables and counts stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_op1_valid,
    input  logic [REG_ADDR_W-1:0] id_op1,
    input  logic                  id_op2_valid,
    input  logic [REG_ADDR_W-1:0] id_op2,
    input  logic                  ex_mem_read,
    input  logic                  ex_wb,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  exmem_hold,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_count
);

    // Remaining-bubble counter is sized for LOAD_LAT up to 7.
    localparam int                 c_BUB_W    = 3;
    localparam logic [c_BUB_W-1:0] c_BUB_INIT = c_BUB_W'(LOAD_LAT - 1);

    hz_state_t          r_state;
    hz_state_t          w_state_d;
    hz_state_t          r_ret;
    hz_state_t          w_ret_d;
    logic [c_BUB_W-1:0] r_bub_cnt;
    logic [c_BUB_W-1:0] w_bub_cnt_d;

    hz_state_t w_eval;
    logic      w_load_use;
    hz_ctrl_t  w_ctrl;
    logic      w_cnt_inc;

    // A load in EX whose destination is read by the ID instruction.
    assign w_load_use = ex_mem_read & ex_wb &
                        ((id_op1_valid & (id_op1 == ex_dst)) |
                         (id_op2_valid & (id_op2 == ex_dst)));

    // Once memory is ready again, MEM_WAIT behaves as the state it interrupted.
    assign w_eval = (r_state == MEM_WAIT) ? r_ret : r_state;

    // State register: reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_ret     <= RUN;
            r_bub_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_ret     <= w_ret_d;
            r_bub_cnt <= w_bub_cnt_d;
        end
    end

    // Next-state logic: mem_busy beats branch_taken beats load-use.
    always_comb begin
        w_state_d   = r_state;
        w_ret_d     = r_ret;
        w_bub_cnt_d = r_bub_cnt;
        if (mem_busy) begin
            // Park, remembering where to resume; bubble count is frozen.
            w_state_d = MEM_WAIT;
            w_ret_d   = w_eval;
        end else begin
            w_ret_d = RUN;
            case (w_eval)
                LU_STALL: begin
                    if (branch_taken) begin
                        w_state_d   = RUN;
                        w_bub_cnt_d = '0;
                    end else begin
                        w_bub_cnt_d = r_bub_cnt - c_BUB_W'(1);
                        w_state_d   = (r_bub_cnt <= c_BUB_W'(1)) ? RUN : LU_STALL;
                    end
                end
                default: begin
                    w_state_d = RUN;
                    if (!branch_taken && w_load_use && (LOAD_LAT > 1)) begin
                        w_state_d   = LU_STALL;
                        w_bub_cnt_d = c_BUB_INIT;
                    end
                end
            endcase
        end
    end

    // Mealy output decode from the effective state and this cycle's inputs.
    always_comb begin
        w_ctrl = CTRL_RUN;
        if (rst) begin
            w_ctrl = CTRL_RESET;
        end else if (mem_busy) begin
            w_ctrl = CTRL_FREEZE;
        end else if (branch_taken) begin
            w_ctrl = CTRL_FLUSH;
        end else if ((w_eval == LU_STALL) || w_load_use) begin
            w_ctrl = CTRL_BUBBLE;
        end
    end

    assign pc_write_en   = w_ctrl.pc_we;
    assign ifid_write_en = w_ctrl.ifid_we;
    assign ifid_flush    = w_ctrl.ifid_flush;
    assign idex_bubble   = w_ctrl.idex_bubble;
    assign exmem_hold    = w_ctrl.exmem_hold;
    assign stall_active  = ~w_ctrl.pc_we;

    // Reset cycles show as stalled but are not counted.
    assign w_cnt_inc = stall_active & ~rst;

    hazard_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_cnt_inc),
        .o_count (stall_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Scoreboard bench for hazard_stall_unit. Two instances
//                (LOAD_LAT=3/CNT_W=16 and LOAD_LAT=1/CNT_W=4) share stimulus;
//                a pending-bubble reference model predicts each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int AW    = 3;
    localparam int LAT_A = 3;
    localparam int CNT_A = 16;
    localparam int LAT_B = 1;
    localparam int CNT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          id_op1_valid;
    logic [AW-1:0] id_op1;
    logic          id_op2_valid;
    logic [AW-1:0] id_op2;
    logic          ex_mem_read;
    logic          ex_wb;
    logic [AW-1:0] ex_dst;
    logic          mem_busy;
    logic          branch_taken;

    logic             a_pc, a_ifid, a_flush, a_bub, a_hold, a_act;
    logic [CNT_A-1:0] a_cnt;
    logic             b_pc, b_ifid, b_flush, b_bub, b_hold, b_act;
    logic [CNT_B-1:0] b_cnt;

    hazard_stall_unit #(.REG_ADDR_W(AW), .LOAD_LAT(LAT_A), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst(rst),
        .id_op1_valid(id_op1_valid), .id_op1(id_op1),
        .id_op2_valid(id_op2_valid), .id_op2(id_op2),
        .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_dst(ex_dst),
        .mem_busy(mem_busy), .branch_taken(branch_taken),
        .pc_write_en(a_pc), .ifid_write_en(a_ifid), .ifid_flush(a_flush),
        .idex_bubble(a_bub), .exmem_hold(a_hold), .stall_active(a_act),
        .stall_count(a_cnt)
    );

    hazard_stall_unit #(.REG_ADDR_W(AW), .LOAD_LAT(LAT_B), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst(rst),
        .id_op1_valid(id_op1_valid), .id_op1(id_op1),
        .id_op2_valid(id_op2_valid), .id_op2(id_op2),
        .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_dst(ex_dst),
        .mem_busy(mem_busy), .branch_taken(branch_taken),
        .pc_write_en(b_pc), .ifid_write_en(b_ifid), .ifid_flush(b_flush),
        .idex_bubble(b_bub), .exmem_hold(b_hold), .stall_active(b_act),
        .stall_count(b_cnt)
    );

    // Expected response: {pc, ifid_we, flush, bubble, hold, stall_active}
    typedef struct {
        logic [5:0] ctrl;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_pend[2];
    int m_cnt[2];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, c, act, exp);
    endtask

    // Reference model: owed bubbles are a plain count, no state machine.
    task automatic model(input int idx, input int lat, input int cmax,
                         output logic [5:0] ctrl, output int cnt_before);
        logic lu;
        lu = ex_mem_read && ex_wb &&
             ((id_op1_valid && id_op1 == ex_dst) || (id_op2_valid && id_op2 == ex_dst));
        cnt_before = m_cnt[idx];
        if (rst) begin
            ctrl        = 6'b001101;
            m_pend[idx] = 0;
            m_cnt[idx]  = 0;
        end else begin
            if (mem_busy) begin
                ctrl = 6'b000011;
            end else if (branch_taken) begin
                ctrl        = 6'b111100;
                m_pend[idx] = 0;
            end else if (m_pend[idx] > 0) begin
                ctrl        = 6'b000101;
                m_pend[idx] = m_pend[idx] - 1;
            end else if (lu) begin
                ctrl        = 6'b000101;
                m_pend[idx] = lat - 1;
            end else begin
                ctrl = 6'b110000;
            end
            if (ctrl[0] && m_cnt[idx] < cmax) m_cnt[idx] = m_cnt[idx] + 1;
        end
    endtask

    // Predict this cycle for both instances, queue it, advance one cycle.
    task automatic issue();
        exp_t e;
        model(0, LAT_A, (1 << CNT_A) - 1, e.ctrl, e.cnt);
        e.cyc = cyc;
        q_a.push_back(e);
        model(1, LAT_B, (1 << CNT_B) - 1, e.ctrl, e.cnt);
        q_b.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 1'b0; id_op1_valid = 1'b0; id_op1 = '0; id_op2_valid = 1'b0; id_op2 = '0;
        ex_mem_read = 1'b0; ex_wb = 1'b0; ex_dst = '0; mem_busy = 1'b0; branch_taken = 1'b0;
    endtask

    // Load r3 in EX, ID reads r3 via op2.
    task automatic load_r3_op2();
        idle();
        ex_mem_read = 1'b1; ex_wb = 1'b1; ex_dst = AW'(3);
        id_op2_valid = 1'b1; id_op2 = AW'(3);
    endtask

    // Monitor: every mid-cycle sample is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("A_ctrl", e.cyc, int'({a_pc, a_ifid, a_flush, a_bub, a_hold, a_act}), int'(e.ctrl));
            chk("A_count", e.cyc, int'(a_cnt), e.cnt);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("B_ctrl", e.cyc, int'({b_pc, b_ifid, b_flush, b_bub, b_hold, b_act}), int'(e.ctrl));
            chk("B_count", e.cyc, int'(b_cnt), e.cnt);
        end
    end

    initial begin
        m_pend[0] = 0; m_pend[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset-state cycle.
        rst = 1'b1; issue();
        idle(); issue();

        // Basic load-use, then defaults.
        load_r3_op2(); issue();
        idle(); repeat (4) issue();

        // No hazard: no writeback, or op1 matching but not valid.
        load_r3_op2(); ex_wb = 1'b0; issue();
        idle(); ex_mem_read = 1'b1; ex_wb = 1'b1; ex_dst = AW'(5);
        id_op1_valid = 1'b0; id_op1 = AW'(5); issue();
        // op1 match that does stall.
        id_op1_valid = 1'b1; issue();
        idle(); repeat (3) issue();

        // Load-use together with a taken branch: flush wins.
        load_r3_op2(); branch_taken = 1'b1; issue();
        idle(); repeat (2) issue();

        // mem_busy for 4 cycles during the second bubble.
        load_r3_op2(); issue();
        idle(); mem_busy = 1'b1; repeat (4) issue();
        idle(); repeat (4) issue();

        // Reset in the middle of a load-use stall.
        load_r3_op2(); issue();
        idle(); issue();
        rst = 1'b1; issue();
        idle(); repeat (3) issue();

        // Long memory stall to saturate the narrow counter.
        idle(); mem_busy = 1'b1; repeat (20) issue();
        idle(); repeat (2) issue();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(99) == 0);
            mem_busy     = ($urandom_range(99) < 12);
            branch_taken = ($urandom_range(99) < 8);
            ex_mem_read  = 1'($urandom_range(1));
            ex_wb        = ($urandom_range(3) != 0);
            ex_dst       = AW'($urandom_range(7));
            id_op1_valid = 1'($urandom_range(1));
            id_op1       = AW'($urandom_range(7));
            id_op2_valid = 1'($urandom_range(1));
            id_op2       = AW'($urandom_range(7));
            issue();
        end

        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", cyc, q_a.size() + q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
